// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, reset PC and buffer entry.
// No latency or backpressure of its own; consumed by fetch_unit and ins_fifo.
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'hBFC0_0000;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DROP,
        ST_IDLE,
        ST_HALT,
        ST_ERR
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        addr_err;
    } fetch_entry_t;

    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ins_fifo.sv
// Shift-register instruction buffer, head always in slot 0; push visible one cycle later.
// Flush beats push and pop; a push into a full buffer is dropped (callers never issue one).
module ins_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_dat,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head_dat,
    output logic          head_vld,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            if (pop && (count_q != '0)) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_d[i] = mem_q[i + 1];
                end
                count_d = count_q - CW'(1);
            end
            // The write slot is the occupancy after any pop this cycle.
            if (push && (count_d < DEPTH_C)) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (count_d == CW'(i)) begin
                        mem_d[i] = push_dat;
                    end
                end
                count_d = count_d + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
        mem_q <= mem_d;
    end

    assign head_dat = mem_q[0];
    assign head_vld = (count_q != '0);
    assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues registered word reads, buffers DEPTH words for decode.
// Data completing at edge N is on ins in cycle N+1; requests stop while buffer plus in-flight is full.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] ins,
    output logic [31:0] pc,
    output logic        insValid,
    output logic        insAddrErr,
    input  logic        insTake,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    input  logic        halt
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t  state_q, state_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          halt_pend_q, halt_pend_d;

    fetch_entry_t  head_dat;
    fetch_entry_t  push_dat;
    logic          head_vld;
    logic          push_vld;
    logic          pop;
    logic          flush;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] cnt_after_push;
    logic          halt_now;

    assign flush          = redirect;
    assign pop            = insTake & head_vld & ~redirect;
    assign halt_now       = halt | halt_pend_q;
    assign cnt_after_push = fifo_count + CW'(1) - CW'(pop);

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        fetch_pc_d  = fetch_pc_q;
        halt_pend_d = halt_pend_q | halt;
        push_vld    = 1'b0;
        push_dat    = '0;

        if (redirect) begin
            halt_pend_d = 1'b0;
            fetch_pc_d  = redirectTarget;
            // The bus cannot abort: an unfinished request is kept and its data dropped.
            if (req_q && !imemReady) begin
                state_d = ST_DROP;
            end else begin
                state_d = ST_FETCH;
                req_d   = is_aligned(redirectTarget);
                if (is_aligned(redirectTarget)) begin
                    addr_d = redirectTarget;
                end
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (req_q) begin
                        if (imemReady) begin
                            push_vld          = 1'b1;
                            push_dat.ins      = imemData;
                            push_dat.pc       = addr_q;
                            fetch_pc_d        = fetch_pc_q + 32'd4;
                            if (halt_now) begin
                                state_d     = ST_HALT;
                                req_d       = 1'b0;
                                halt_pend_d = 1'b0;
                            end else if (cnt_after_push < DEPTH_C) begin
                                addr_d = fetch_pc_q + 32'd4;
                            end else begin
                                state_d = ST_IDLE;
                                req_d   = 1'b0;
                            end
                        end
                    end else if (halt_now) begin
                        state_d     = ST_HALT;
                        halt_pend_d = 1'b0;
                    end else if (!is_aligned(fetch_pc_q)) begin
                        // Misaligned target: hand decode a nop marked as a fetch error.
                        push_vld          = 1'b1;
                        push_dat.pc       = fetch_pc_q;
                        push_dat.addr_err = 1'b1;
                        state_d           = ST_ERR;
                    end else if (fifo_count < DEPTH_C) begin
                        req_d  = 1'b1;
                        addr_d = fetch_pc_q;
                    end
                end
                ST_DROP: begin
                    if (imemReady) begin
                        req_d = 1'b0;
                        if (!is_aligned(fetch_pc_q)) begin
                            push_vld          = 1'b1;
                            push_dat.pc       = fetch_pc_q;
                            push_dat.addr_err = 1'b1;
                            state_d           = ST_ERR;
                        end else if (halt_now) begin
                            state_d     = ST_HALT;
                            halt_pend_d = 1'b0;
                        end else begin
                            state_d = ST_FETCH;
                            req_d   = 1'b1;
                            addr_d  = fetch_pc_q;
                        end
                    end
                end
                ST_IDLE: begin
                    if (halt_now) begin
                        state_d     = ST_HALT;
                        halt_pend_d = 1'b0;
                    end else if (fifo_count < DEPTH_C) begin
                        state_d = ST_FETCH;
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_q;
                    end
                end
                ST_HALT, ST_ERR: begin
                    req_d = 1'b0;
                end
                default: begin
                    state_d = ST_FETCH;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            req_q       <= 1'b0;
            addr_q      <= '0;
            fetch_pc_q  <= RESET_PC;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            fetch_pc_q  <= fetch_pc_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    ins_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_ins_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_vld),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (flush),
        .head_dat (head_dat),
        .head_vld (head_vld),
        .count    (fifo_count)
    );

    assign imemReq    = req_q;
    assign imemAddr   = addr_q;
    assign insValid   = head_vld;
    assign ins        = head_vld ? head_dat.ins : 32'd0;
    assign pc         = head_vld ? head_dat.pc  : 32'd0;
    assign insAddrErr = head_vld & head_dat.addr_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory model answers reads, and every word decode takes is checked
// against the expected in-order stream from the last reset or redirect target.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        insValid;
    logic        insAddrErr;
    logic        insTake;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic        halt;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_cmpl   = 0;
    int          n_taken  = 0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imemData = mem_word(imemAddr);

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imemReq        (imemReq),
        .imemAddr       (imemAddr),
        .imemReady      (imemReady),
        .imemData       (imemData),
        .ins            (ins),
        .pc             (pc),
        .insValid       (insValid),
        .insAddrErr     (insAddrErr),
        .insTake        (insTake),
        .redirect       (redirect),
        .redirectTarget (redirectTarget),
        .halt           (halt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Expected program-order stream starting at t; a misaligned target yields one error marker.
    task automatic new_stream(input logic [31:0] t);
        exp_q.delete();
        if (t[1:0] != 2'b00) begin
            exp_q.push_back('{32'd0, t, 1'b1});
        end else begin
            for (int i = 0; i < 64; i++) begin
                exp_q.push_back('{mem_word(t + 32'(4 * i)), t + 32'(4 * i), 1'b0});
            end
        end
    endtask

    task automatic step();
        logic        r;
        logic        rs;
        logic [31:0] t;
        r  = redirect;
        rs = rst;
        t  = redirectTarget;
        @(posedge clk);
        #1;
        if (rs) new_stream(RST_PC);
        else if (r) new_stream(t);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        redirect  = 1'b0;
        halt      = 1'b0;
        insTake   = 1'b0;
        imemReady = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect       = 1'b1;
        redirectTarget = t;
        step();
        redirect = 1'b0;
    endtask

    task automatic count_req(input int n, output int c);
        c = 0;
        repeat (n) begin
            if (imemReq) c++;
            step();
        end
    endtask

    // Monitor: bus hold rule, alignment, and every consumed entry against the expected stream.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_pend) begin
                chk("req_held", 32'(imemReq), 32'd1);
                chk("addr_held", imemAddr, prev_addr);
            end
            if (imemReq && imemReady) begin
                n_cmpl++;
                chk("addr_align", {30'd0, imemAddr[1:0]}, 32'd0);
            end
            if (insValid && insTake && !redirect) begin
                n_taken++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_entry: got pc %h, expected no entry", pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("stream_ins", ins, mon_e.ins);
                    chk("stream_pc", pc, mon_e.pc);
                    chk("stream_err", 32'(insAddrErr), 32'(mon_e.err));
                end
            end
        end
        prev_pend = !rst && imemReq && !imemReady;
        prev_addr = imemAddr;
    end

    initial begin
        int          base;
        int          c;
        int          run;
        logic [31:0] t;

        rst            = 1'b1;
        imemReady      = 1'b0;
        insTake        = 1'b0;
        redirect       = 1'b0;
        redirectTarget = 32'd0;
        halt           = 1'b0;

        do_reset();
        chk("rst_req", 32'(imemReq), 32'd0);
        chk("rst_addr", imemAddr, 32'd0);
        chk("rst_valid", 32'(insValid), 32'd0);
        chk("rst_err", 32'(insAddrErr), 32'd0);
        chk("rst_ins", ins, 32'd0);
        chk("rst_pc", pc, 32'd0);

        // Streaming at full rate from reset.
        imemReady = 1'b1;
        insTake   = 1'b1;
        step();
        chk("first_req", 32'(imemReq), 32'd1);
        chk("first_addr", imemAddr, RST_PC);
        chk("first_valid_early", 32'(insValid), 32'd0);
        step();
        chk("first_valid", 32'(insValid), 32'd1);
        chk("seq_pc0", pc, RST_PC);
        step();
        chk("seq_pc1", pc, RST_PC + 32'd4);
        step();
        chk("seq_pc2", pc, RST_PC + 32'd8);

        // No consumption: buffer fills to two and requests stop.
        do_reset();
        base      = n_cmpl;
        imemReady = 1'b1;
        repeat (6) step();
        chk("full_req", 32'(imemReq), 32'd0);
        chk("full_fetched", 32'(n_cmpl - base), 32'd2);
        chk("full_head_pc", pc, RST_PC);
        insTake = 1'b1;
        step();
        insTake = 1'b0;
        for (int k = 0; k < 4 && !imemReq; k++) step();
        chk("refill_req", 32'(imemReq), 32'd1);
        chk("refill_addr", imemAddr, RST_PC + 32'd8);

        // Redirect while a request is stalled: old data must be dropped.
        do_reset();
        insTake = 1'b1;
        step();
        do_redirect(32'h8000_0180);
        chk("drop_req", 32'(imemReq), 32'd1);
        chk("drop_addr", imemAddr, RST_PC);
        chk("drop_flush", 32'(insValid), 32'd0);
        step();
        step();
        imemReady = 1'b1;
        step();
        chk("drop_next_addr", imemAddr, 32'h8000_0180);
        chk("drop_stale", 32'(insValid), 32'd0);
        step();
        chk("drop_target_pc", pc, 32'h8000_0180);

        // Redirect on the completing edge: no drop cycle.
        do_reset();
        imemReady = 1'b1;
        insTake   = 1'b1;
        step();
        do_redirect(32'h0000_1000);
        chk("coinc_req", 32'(imemReq), 32'd1);
        chk("coinc_addr", imemAddr, 32'h0000_1000);
        chk("coinc_flush", 32'(insValid), 32'd0);
        step();
        chk("coinc_pc", pc, 32'h0000_1000);

        // Misaligned target.
        insTake = 1'b0;
        do_redirect(32'h0040_0002);
        for (int k = 0; k < 4 && !insValid; k++) step();
        chk("mis_valid", 32'(insValid), 32'd1);
        chk("mis_err", 32'(insAddrErr), 32'd1);
        chk("mis_ins", ins, 32'd0);
        chk("mis_pc", pc, 32'h0040_0002);
        count_req(5, c);
        chk("mis_noreq", 32'(c), 32'd0);
        insTake = 1'b1;
        step();
        insTake = 1'b0;

        // Halt with one request in flight.
        do_reset();
        step();
        halt = 1'b1;
        step();
        halt      = 1'b0;
        imemReady = 1'b1;
        step();
        chk("halt_req", 32'(imemReq), 32'd0);
        chk("halt_valid", 32'(insValid), 32'd1);
        chk("halt_pc", pc, RST_PC);
        count_req(5, c);
        chk("halt_noreq", 32'(c), 32'd0);
        insTake = 1'b1;
        do_redirect(32'h0040_0000);
        chk("resume_req", 32'(imemReq), 32'd1);
        chk("resume_addr", imemAddr, 32'h0040_0000);

        // PC wraps modulo 2^32.
        do_redirect(32'hFFFF_FFF8);
        step();
        step();
        step();
        chk("wrap_pc", pc, 32'd0);

        // Random bursts of bus stalls, decode stalls and redirects.
        do_reset();
        repeat (40) begin
            run = $urandom_range(1, 40);
            repeat (run) begin
                imemReady = ($urandom_range(0, 3) != 0);
                insTake   = ($urandom_range(0, 2) != 0);
                step();
            end
            case ($urandom_range(0, 7))
                0:       t = $urandom | 32'd1;
                1:       t = 32'hFFFF_FFF0;
                default: t = $urandom & ~32'd3;
            endcase
            imemReady = ($urandom_range(0, 1) != 0);
            do_redirect(t);
        end
        chk("progress", 32'(n_taken > 50), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
